// File: rtl/seq_det_prog.sv
// Runtime-programmable serial pattern detector with overlap control, sample enable
// and a saturating detection counter.
module seq_det_prog #(
  parameter int                    MAX_LEN     = 8,
  parameter int                    CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]    DEF_PATTERN = MAX_LEN'('b0000_1011),
  parameter int                    DEF_LEN     = 4,
  parameter logic                  DEF_OVERLAP = 1'b1,
  localparam int                   LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               seq_in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               det_o,
  output logic [CNT_W-1:0]   det_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic               r_det;
  logic [CNT_W-1:0]   r_count;
  logic               r_err;

  logic [MAX_LEN-1:0] w_hist_n;
  logic [LEN_W:0]     w_fill_inc;
  logic [LEN_W-1:0]   w_fill_n;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_cfg_ok;
  logic               w_cfg_bad;
  logic               w_match;

  // Comparison mask covering only the active low len bits of the pattern.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] n);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  always_comb begin
    w_hist_n   = {r_hist[MAX_LEN-2:0], seq_in};
    w_fill_inc = {1'b0, r_fill} + 1'b1;
    w_fill_n   = (w_fill_inc >= {1'b0, r_len}) ? r_len : w_fill_inc[LEN_W-1:0];
    w_mask     = len_mask(r_len);
    w_cfg_ok   = cfg_load && (cfg_len != '0) &&
                 ({1'b0, cfg_len} <= (LEN_W + 1)'(MAX_LEN));
    w_cfg_bad  = cfg_load && !w_cfg_ok;
    // An accepted load discards this cycle's sample; a rejected one does not.
    w_match    = en && !w_cfg_ok && (w_fill_n == r_len) &&
                 (((w_hist_n ^ r_pattern) & w_mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= DEF_PATTERN;
      r_len     <= LEN_W'(DEF_LEN);
      r_overlap <= DEF_OVERLAP;
      r_det     <= 1'b0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_cfg_bad;
      if (cnt_clr) begin
        r_count <= '0;
      end else if (w_match) begin
        r_count <= sat_inc(r_count);
      end
      if (w_cfg_ok) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_fill    <= '0;
        r_hist    <= '0;
        r_det     <= 1'b0;
      end else if (en) begin
        r_hist <= w_hist_n;
        // Non-overlapping mode restarts the fill so no matched bit is reused.
        r_fill <= (w_match && !r_overlap) ? '0 : w_fill_n;
        r_det  <= w_match;
      end else begin
        r_det <= 1'b0;
      end
    end
  end

  assign det_o     = r_det;
  assign det_count = r_count;
  assign cfg_err   = r_err;

endmodule
